// File: rtl/wall_clock_pkg.sv
// ---------------------------------------------------------------------------
// wall_clock_pkg
//   Shared types and constants for the wall-clock display block.
//   - state_e      : conversion FSM states (IDLE, CONV, COMMIT)
//   - dbg_t        : debug snapshot of the control state, for probes/checkers
//   - CODE_*       : special digit codes held in the display buffer
//   - SEG_*        : active-low segment patterns {g,f,e,d,c,b,a}
//   - *_MAX        : largest valid value of each time field
// ---------------------------------------------------------------------------
package wall_clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    state_e     state;
    logic [1:0] idx;
    logic       tick;
    logic       frame_start;
  } dbg_t;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

endpackage

// File: rtl/wall_clock_display_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Purely combinational digit-code to seven-segment decoder.
//   Ports:
//     code_i [3:0] : digit code (0-9 numerals, CODE_DASH, anything else blank)
//     seg_o  [6:0] : segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_decode
  import wall_clock_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:      seg_o = 7'b1000000;
      4'd1:      seg_o = 7'b1111001;
      4'd2:      seg_o = 7'b0100100;
      4'd3:      seg_o = 7'b0110000;
      4'd4:      seg_o = 7'b0011001;
      4'd5:      seg_o = 7'b0010010;
      4'd6:      seg_o = 7'b0000010;
      4'd7:      seg_o = 7'b1111000;
      4'd8:      seg_o = 7'b0000000;
      4'd9:      seg_o = 7'b0010000;
      CODE_DASH: seg_o = SEG_DASH;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/wall_clock_display.sv
// ---------------------------------------------------------------------------
// wall_clock_display
//   Converts binary hours/minutes from the clock core to BCD with a
//   sequential repeated-subtraction engine and drives a 4-digit multiplexed
//   active-low seven-segment display as HH.MM, dp blinking on seconds[0].
//
//   Parameter:
//     SCAN_DIV  : system clock cycles per digit slot (>= 16)
//   Ports:
//     Clock         : system clock, rising edge
//     reset         : asynchronous, active-low reset
//     seconds [5:0] : binary seconds (only bit 0 is used, for the dp blink)
//     minutes [5:0] : binary minutes, 0-59 valid
//     hours   [4:0] : binary hours, 0-23 valid
//     an      [3:0] : digit enables, active-low (an[0] = minutes units)
//     seg     [6:0] : segments {g,f,e,d,c,b,a}, active-low
//     dp            : decimal point / colon, active-low
//
//   Build option:
//     WALL_CLOCK_LZB_EN : blank the hours-tens digit when it is zero.
//
//   Inputs are sampled only at frame-start (the tick where the digit index
//   wraps 3->0). The display buffer is written atomically in COMMIT, so a
//   frame never shows a mix of old and new digits.
// ---------------------------------------------------------------------------
module wall_clock_display
  import wall_clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  // ---------------- scan timing ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick;
  logic          frame_start;

  assign tick        = (presc_q == PRESC_LAST);
  assign frame_start = tick && (idx_q == 2'd3);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------- conversion FSM ----------------
  state_e state_q, state_d;

  // Working registers: units remainder and tens count per field.
  logic [4:0] hr_w_q, hr_w_d;
  logic [5:0] mn_w_q, mn_w_d;
  logic [1:0] hr_t_q, hr_t_d;   // hours up to 31 -> tens up to 3
  logic [2:0] mn_t_q, mn_t_d;   // minutes up to 63 -> tens up to 6
  logic       sec0_q, sec0_d;
  logic       hr_bad_q, hr_bad_d;
  logic       mn_bad_q, mn_bad_d;

  logic all_lt10;
  assign all_lt10 = (hr_w_q < 5'd10) && (mn_w_q < 6'd10);

  // FSM control strobes
  logic do_load;
  logic do_step;
  logic do_commit;

  // State register
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = CONV;
      CONV:    if (all_lt10)    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output (control) logic
  always_comb begin
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      IDLE:    do_load   = frame_start;
      CONV:    do_step   = !all_lt10;
      COMMIT:  do_commit = 1'b1;
      default: ;
    endcase
  end

  // Working-register datapath. Fields >= 10 are reduced in parallel, so the
  // conversion takes as many steps as the largest tens digit.
  always_comb begin
    hr_w_d   = hr_w_q;
    mn_w_d   = mn_w_q;
    hr_t_d   = hr_t_q;
    mn_t_d   = mn_t_q;
    sec0_d   = sec0_q;
    hr_bad_d = hr_bad_q;
    mn_bad_d = mn_bad_q;
    if (do_load) begin
      hr_w_d   = hours;
      mn_w_d   = minutes;
      hr_t_d   = 2'd0;
      mn_t_d   = 3'd0;
      sec0_d   = seconds[0];
      hr_bad_d = (hours > HOURS_MAX);
      mn_bad_d = (minutes > MINUTES_MAX);
    end else if (do_step) begin
      if (hr_w_q >= 5'd10) begin
        hr_w_d = hr_w_q - 5'd10;
        hr_t_d = hr_t_q + 2'd1;
      end
      if (mn_w_q >= 6'd10) begin
        mn_w_d = mn_w_q - 6'd10;
        mn_t_d = mn_t_q + 3'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      hr_w_q   <= '0;
      mn_w_q   <= '0;
      hr_t_q   <= '0;
      mn_t_q   <= '0;
      sec0_q   <= 1'b0;
      hr_bad_q <= 1'b0;
      mn_bad_q <= 1'b0;
    end else begin
      hr_w_q   <= hr_w_d;
      mn_w_q   <= mn_w_d;
      hr_t_q   <= hr_t_d;
      mn_t_q   <= mn_t_d;
      sec0_q   <= sec0_d;
      hr_bad_q <= hr_bad_d;
      mn_bad_q <= mn_bad_d;
    end
  end

  // ---------------- display buffer ----------------
  logic [3:0][3:0] buf_q, buf_d;   // [3]=hours tens ... [0]=minutes units
  logic            buf_dp_q, buf_dp_d;
  logic [3:0]      hr_tens_code;

  always_comb begin
`ifdef WALL_CLOCK_LZB_EN
    hr_tens_code = (hr_t_q == 2'd0) ? CODE_BLANK : {2'b00, hr_t_q};
`else
    hr_tens_code = {2'b00, hr_t_q};
`endif
  end

  always_comb begin
    buf_d    = buf_q;
    buf_dp_d = buf_dp_q;
    if (do_commit) begin
      buf_d[3] = hr_bad_q ? CODE_DASH : hr_tens_code;
      buf_d[2] = hr_bad_q ? CODE_DASH : hr_w_q[3:0];
      buf_d[1] = mn_bad_q ? CODE_DASH : {1'b0, mn_t_q};
      buf_d[0] = mn_bad_q ? CODE_DASH : mn_w_q[3:0];
      buf_dp_d = sec0_q;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      buf_q    <= '0;
      buf_dp_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      buf_dp_q <= buf_dp_d;
    end
  end

  // ---------------- output stage ----------------
  logic [3:0] cur_code;
  logic [6:0] cur_seg;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  assign cur_code = buf_q[idx_q];

  seg7_decode u_dec (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

  // A blanked digit also releases its anode so nothing is driven at all.
  always_comb begin
    an_d  = (cur_code == CODE_BLANK) ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = cur_seg;
    dp_d  = !((idx_q == 2'd2) && buf_dp_q);
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

  // ---------------- debug view ----------------
  // Control state gathered in one struct for probes and bound checkers.
  dbg_t dbg_state;
  assign dbg_state = '{state: state_q, idx: idx_q, tick: tick,
                       frame_start: frame_start};

  // Upper seconds bits are intentionally ignored; the debug struct has no
  // in-design consumer. Reduce both so lint sees them consumed.
  logic unused_sigs;
  assign unused_sigs = ^{dbg_state, seconds[5:1]};

endmodule

// File: tb/tb_wall_clock_display.sv
// ---------------------------------------------------------------------------
// tb_wall_clock_display
//   Directed, table-driven bench for wall_clock_display with SCAN_DIV = 16.
//   Edge n after reset release (n = 1, 2, ...) leaves the prescaler at
//   n mod 16; frame-starts fall on edges 64, 128, ... . Each digit slot is
//   sampled 12 edges into the slot, after any conversion has committed and
//   passed the one-cycle output register.
// ---------------------------------------------------------------------------
module tb_wall_clock_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'h7F;

`ifdef WALL_CLOCK_LZB_EN
  localparam logic [6:0] Z3_SEG   = SB;
  localparam logic       Z3_BLANK = 1'b1;
`else
  localparam logic [6:0] Z3_SEG   = S0;
  localparam logic       Z3_BLANK = 1'b0;
`endif

  typedef struct {
    logic [4:0]      h;
    logic [5:0]      m;
    logic [5:0]      s;
    logic [3:0][6:0] seg;     // expected seg per slot, [3] = hours tens
    logic            blank3;  // hours-tens slot expected blank (an all high)
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic       Clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 Clock = ~Clock;

  wall_clock_display #(.SCAN_DIV(16)) dut (
    .Clock   (Clock),
    .reset   (reset),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  int cyc;
  always @(posedge Clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge Clock);
    if (cyc != target) begin
      checks++;
      failures++;
      $display("FAIL sync: at cyc %0d expected cyc %0d", cyc, target);
    end
  endtask

  function automatic int next_fs();
    return ((cyc / 64) + 1) * 64;
  endfunction

  function automatic logic [3:0] an_for(input int s, input logic blank);
    logic [3:0] r;
    if (blank) r = 4'b1111;
    else case (s)
      0: r = 4'b1110;
      1: r = 4'b1101;
      2: r = 4'b1011;
      default: r = 4'b0111;
    endcase
    return r;
  endfunction

  task automatic check_slot(input int fs, input int s, input logic [6:0] eseg,
                            input logic blank, input logic dp_low);
    wait_cyc(fs + 16 * s + 12);
    cmp($sformatf("an slot%0d", s), {28'd0, an}, {28'd0, an_for(s, blank)});
    cmp($sformatf("seg slot%0d", s), {25'd0, seg}, {25'd0, eseg});
    cmp($sformatf("dp slot%0d", s), {31'd0, dp}, {31'd0, !dp_low});
  endtask

  task automatic check_frame(input int fs, input vec_t v);
    for (int s = 0; s < 4; s++)
      check_slot(fs, s, v.seg[s], (s == 3) && v.blank3, (s == 2) && v.s[0]);
  endtask

  task automatic set_inputs(input vec_t v);
    @(negedge Clock);
    hours   = v.h;
    minutes = v.m;
    seconds = v.s;
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic pulse_reset();
    @(negedge Clock);
    #2 reset = 1'b0;
    #1;
    cmp("async an", {28'd0, an}, 32'hF);
    cmp("async seg", {25'd0, seg}, 32'h7F);
    cmp("async dp", {31'd0, dp}, 32'd1);
    @(negedge Clock);
    @(negedge Clock);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                              input logic [6:0] g3, input logic [6:0] g2,
                              input logic [6:0] g1, input logic [6:0] g0,
                              input logic b3);
    vec_t v;
    v.h = h; v.m = m; v.s = s;
    v.seg = {g3, g2, g1, g0};
    v.blank3 = b3;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[10];
  vec_t zero_v;
  vec_t v2359;
  vec_t v1234;

  initial begin
    int fs;

    vecs[0] = mk(5'd23, 6'd59, 6'd1, S2, S3, S5, S9, 1'b0);
    vecs[1] = mk(5'd24, 6'd7,  6'd0, SD, SD, S0, S7, 1'b0);
    vecs[2] = mk(5'd24, 6'd7,  6'd1, SD, SD, S0, S7, 1'b0);
    vecs[3] = mk(5'd9,  6'd5,  6'd0, Z3_SEG, S9, S0, S5, Z3_BLANK);
    vecs[4] = mk(5'd12, 6'd34, 6'd1, S1, S2, S3, S4, 1'b0);
    vecs[5] = mk(5'd0,  6'd60, 6'd0, Z3_SEG, S0, SD, SD, Z3_BLANK);
    vecs[6] = mk(5'd31, 6'd63, 6'd1, SD, SD, SD, SD, 1'b0);
    vecs[7] = mk(5'd19, 6'd48, 6'd0, S1, S9, S4, S8, 1'b0);
    vecs[8] = mk(5'd20, 6'd0,  6'd3, S2, S0, S0, S0, 1'b0);
    vecs[9] = mk(5'd16, 6'd26, 6'd58, S1, S6, S2, S6, 1'b0);
    // Buffer after reset holds code 0 everywhere, so hours-tens shows '0'
    // even when leading-zero blanking is enabled.
    zero_v  = mk(5'd0, 6'd0, 6'd0, S0, S0, S0, S0, 1'b0);
    v2359   = vecs[0];
    v1234   = vecs[4];

    // Reset held at start, then released on a falling edge.
    repeat (3) @(negedge Clock);
    cmp("reset an", {28'd0, an}, 32'hF);
    cmp("reset seg", {25'd0, seg}, 32'h7F);
    cmp("reset dp", {31'd0, dp}, 32'd1);
    reset = 1'b1;

    // Scenario 1: async reset mid-frame, then first frame shows 00.00.
    wait_cyc(30);
    pulse_reset();
    check_frame(0, zero_v);

    // Table of directed vectors, one frame each.
    for (int i = 0; i < 10; i++) begin
      set_inputs(vecs[i]);
      fs = next_fs();
      check_frame(fs, vecs[i]);
    end

    // Commit latency for 23:59 is 7 edges; output register adds one more.
    set_inputs(v1234);
    fs = next_fs();
    check_frame(fs, v1234);
    set_inputs(v2359);
    fs = next_fs();
    wait_cyc(fs + 7);
    cmp("latency old slot0", {25'd0, seg}, {25'd0, S4});
    wait_cyc(fs + 8);
    cmp("latency new slot0", {25'd0, seg}, {25'd0, S9});
    for (int s = 1; s < 4; s++)
      check_slot(fs, s, v2359.seg[s], 1'b0, s == 2);

    // Scenario 4: minutes change mid-frame are not shown until next frame.
    set_inputs(mk(5'd12, 6'd10, 6'd0, S1, S2, S1, S0, 1'b0));
    fs = next_fs();
    check_slot(fs, 0, S0, 1'b0, 1'b0);
    minutes = 6'd11;
    check_slot(fs, 1, S1, 1'b0, 1'b0);
    check_slot(fs, 2, S2, 1'b0, 1'b0);
    check_slot(fs, 3, S1, 1'b0, 1'b0);
    check_frame(fs + 64, mk(5'd12, 6'd11, 6'd0, S1, S2, S1, S1, 1'b0));

    // Scenario 5: reset during CONV; buffer clears, next frame converts.
    set_inputs(v2359);
    fs = next_fs();
    wait_cyc(fs + 2);
    pulse_reset();
    check_frame(0, zero_v);
    check_frame(64, v2359);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
